// File: rtl/bus_pkg.sv
// bus_pkg: shared memory-bus encodings, requester indices and arbiter states.
package bus_pkg;
  localparam logic [1:0] W_BYTE = 2'd0;
  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_WORD = 2'd2;
  localparam int REQ_DMA0 = 0;
  localparam int REQ_DMA1 = 1;
  localparam int REQ_DMA2 = 2;
  localparam int REQ_DMA3 = 3;
  localparam int REQ_CPU  = 4;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/arb_prio_enc.sv
// arb_prio_enc: fixed-priority encoder, index 0 wins; one-hot grant plus index.
module arb_prio_enc #(
  parameter int N = 5
) (
  input  logic [N-1:0]         req,
  output logic [N-1:0]         onehot,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);
  localparam int IW = $clog2(N);
  assign onehot = req & (~req + N'(1));
  assign any = |req;
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (req[i]) idx = IW'(i);
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: fixed-priority sharing of one memory port, with bus timeout and bounded locked bursts.
module mem_bus_arbiter
  import bus_pkg::*;
#(
  parameter int N         = 5,
  parameter int TIMEOUT   = 255,
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  lock,
  input  logic [N*32-1:0] addr,
  input  logic [N*32-1:0] wdata,
  input  logic [N*2-1:0]  width,
  input  logic [N-1:0]  we,
  output logic [N-1:0]  ack,
  output logic          err,
  output logic [31:0]   rdata,
  output logic [N-1:0]  gnt,
  output logic [31:0]   m_addr,
  output logic [31:0]   m_wdata,
  output logic [1:0]    m_width,
  output logic          m_read,
  output logic          m_write,
  input  logic [31:0]   m_rdata,
  input  logic          m_ok
);
  localparam int IW = $clog2(N);
  state_t state, state_n;
  logic [N-1:0] pe_gnt;
  logic [IW-1:0] pe_idx, own, sel;
  logic pe_any, issue, fin, tout;
  logic [7:0] cnt, burst;
  logic [1:0] w_sel;
  arb_prio_enc #(.N(N)) u_enc (.req(req), .onehot(pe_gnt), .idx(pe_idx), .any(pe_any));
  always_comb begin
    state_n = state;
    issue = 1'b0;
    fin = 1'b0;
    tout = 1'b0;
    sel = own;
    case (state)
      IDLE: if (pe_any) begin
        issue = 1'b1;
        sel = pe_idx;
        state_n = BUSY;
      end
      BUSY: if (m_ok || cnt == 8'(TIMEOUT)) begin
        fin = 1'b1;
        tout = !m_ok;
        state_n = DONE;
      end
      DONE: begin
        issue = lock[own] && req[own] && burst < 8'(MAX_BURST);
        state_n = issue ? BUSY : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  assign w_sel = width[2*int'(sel) +: 2];
  // burst counts grants in the current ownership, so MAX_BURST=1 never re-issues
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      own <= '0;
      cnt <= '0;
      burst <= '0;
      ack <= '0;
      err <= 1'b0;
      rdata <= '0;
      gnt <= '0;
      m_addr <= '0;
      m_wdata <= '0;
      m_width <= W_WORD;
      m_read <= 1'b0;
      m_write <= 1'b0;
    end else begin
      state <= state_n;
      ack <= '0;
      err <= 1'b0;
      if (state == BUSY && cnt != 8'(TIMEOUT)) cnt <= cnt + 8'd1;
      if (issue) begin
        own <= sel;
        cnt <= 8'd1;
        burst <= (state == IDLE) ? 8'd1 : burst + 8'd1;
        if (state == IDLE) gnt <= pe_gnt;
        m_addr <= addr[32*int'(sel) +: 32];
        m_wdata <= wdata[32*int'(sel) +: 32];
        m_width <= (w_sel == 2'd3) ? W_WORD : w_sel;
        m_write <= we[sel];
        m_read <= !we[sel];
      end
      if (fin) begin
        m_read <= 1'b0;
        m_write <= 1'b0;
        ack <= gnt;
        err <= tout;
        rdata <= tout ? '0 : m_rdata;
      end
      if (state == DONE && !issue) begin
        gnt <= '0;
        burst <= '0;
      end
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed and randomized scenarios checked against a transaction-order model.
module tb_mem_bus_arbiter;
  import bus_pkg::*;
  localparam int N = 5, TO = 8, MB = 16, MAXT = 24;
  logic clk = 1'b0, rstn;
  logic [N-1:0] req, lock, we, ack, gnt;
  logic [N*32-1:0] addr, wdata;
  logic [N*2-1:0] width;
  logic err, m_read, m_write, m_ok;
  logic [31:0] rdata, m_addr, m_wdata, m_rdata;
  logic [1:0] m_width;
  int checks = 0, errors = 0;
  typedef struct {int lat; logic [31:0] data;} mem_t;
  typedef struct {int i; int k; bit first;} ent_t;
  mem_t mem_q[$];
  bit glitch = 1'b0;
  int cnt[N];
  bit lockm[N];
  logic [31:0] t_addr[N][MAXT], t_wdata[N][MAXT], t_data[N][MAXT];
  logic [1:0] t_width[N][MAXT];
  logic t_we[N][MAXT];
  int t_lat[N][MAXT];

  always #5 clk = ~clk;

  mem_bus_arbiter #(.N(N), .TIMEOUT(TO), .MAX_BURST(MB)) dut (
    .clk(clk), .rstn(rstn), .req(req), .lock(lock), .addr(addr), .wdata(wdata),
    .width(width), .we(we), .ack(ack), .err(err), .rdata(rdata), .gnt(gnt),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_width(m_width), .m_read(m_read),
    .m_write(m_write), .m_rdata(m_rdata), .m_ok(m_ok));

  // memory: each new strobe takes the next {latency, data}; latency 0 never answers
  mem_t cur;
  int scnt;
  initial begin
    m_ok = 1'b0;
    m_rdata = '0;
    scnt = 0;
    cur = '{1, 32'h0};
    forever begin
      @(posedge clk);
      #1;
      if (m_read || m_write) begin
        if (scnt == 0) cur = (mem_q.size() > 0) ? mem_q.pop_front() : '{1, 32'h0};
        scnt++;
        m_ok = (scnt == cur.lat);
        m_rdata = m_ok ? cur.data : $urandom;
      end else begin
        scnt = 0;
        m_ok = glitch ? 1'($urandom_range(0, 1)) : 1'b0;
        m_rdata = $urandom;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int i, input int k);
    addr[32*i +: 32] = t_addr[i][k];
    wdata[32*i +: 32] = t_wdata[i][k];
    width[2*i +: 2] = t_width[i][k];
    we[i] = t_we[i][k];
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      lockm[i] = 1'b0;
    end
  endtask

  task automatic fill(input int lat_lo, input int lat_hi, input int to_pct);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < MAXT; k++) begin
        t_addr[i][k] = $urandom;
        t_wdata[i][k] = $urandom;
        t_data[i][k] = $urandom;
        t_width[i][k] = 2'($urandom_range(0, 3));
        t_we[i][k] = 1'($urandom_range(0, 1));
        t_lat[i][k] = ($urandom_range(0, 99) < to_pct) ? 0 : $urandom_range(lat_lo, lat_hi);
      end
  endtask

  // model: lowest pending index owns the bus; a locking requester keeps it for up to MB accesses
  task automatic run_scenario(input string nm);
    int rem[N], kk[N], k[N];
    ent_t ord[$], sq[$];
    ent_t e;
    int g, n, scyc;
    bit prev, idle_seen, strobe, exp_err;
    logic [N-1:0] exp_oh;
    logic [1:0] exp_w;
    for (int i = 0; i < N; i++) begin
      rem[i] = cnt[i];
      kk[i] = 0;
    end
    forever begin
      g = -1;
      for (int i = N - 1; i >= 0; i--) if (rem[i] > 0) g = i;
      if (g < 0) break;
      n = lockm[g] ? ((rem[g] < MB) ? rem[g] : MB) : 1;
      for (int j = 0; j < n; j++) begin
        ord.push_back('{g, kk[g], j == 0});
        kk[g]++;
        rem[g]--;
      end
    end
    sq = ord;
    mem_q.delete();
    foreach (ord[j]) mem_q.push_back('{t_lat[ord[j].i][ord[j].k], t_data[ord[j].i][ord[j].k]});
    for (int i = 0; i < N; i++) begin
      k[i] = 0;
      if (cnt[i] > 0) begin
        load(i, 0);
        req[i] = 1'b1;
        lock[i] = lockm[i];
      end
    end
    prev = 1'b0;
    idle_seen = 1'b1;
    scyc = 0;
    for (int c = 0; c < 5000 && ord.size() > 0; c++) begin
      tick();
      strobe = m_read | m_write;
      if (strobe && !prev) begin
        checks++;
        if (sq.size() == 0) begin
          errors++;
          $display("FAIL %s_extra_strobe: got strobe with no access pending, want none", nm);
        end else begin
          e = sq.pop_front();
          exp_oh = N'(1) << e.i;
          exp_w = (t_width[e.i][e.k] == 2'd3) ? W_WORD : t_width[e.i][e.k];
          if (m_addr !== t_addr[e.i][e.k] || m_wdata !== t_wdata[e.i][e.k] || m_width !== exp_w ||
              m_write !== t_we[e.i][e.k] || m_read !== !t_we[e.i][e.k] || gnt !== exp_oh) begin
            errors++;
            $display("FAIL %s_issue: got a=%h d=%h w=%0d wr=%b rd=%b gnt=%b want a=%h d=%h w=%0d wr=%b gnt=%b",
                     nm, m_addr, m_wdata, m_width, m_write, m_read, gnt,
                     t_addr[e.i][e.k], t_wdata[e.i][e.k], exp_w, t_we[e.i][e.k], exp_oh);
          end
        end
        scyc = 0;
      end
      if (strobe) scyc++;
      if (gnt == '0) idle_seen = 1'b1;
      if (ack != '0) begin
        e = ord.pop_front();
        exp_oh = N'(1) << e.i;
        exp_err = (t_lat[e.i][e.k] == 0);
        checks++;
        if (ack !== exp_oh || err !== exp_err || rdata !== (exp_err ? 32'h0 : t_data[e.i][e.k])) begin
          errors++;
          $display("FAIL %s_ack: got ack=%b err=%b rdata=%h want ack=%b err=%b rdata=%h",
                   nm, ack, err, rdata, exp_oh, exp_err, exp_err ? 32'h0 : t_data[e.i][e.k]);
        end
        checks++;
        if (scyc !== (exp_err ? TO : t_lat[e.i][e.k]) || idle_seen !== e.first) begin
          errors++;
          $display("FAIL %s_timing: got strobe_cycles=%0d idle_before=%b want %0d %b",
                   nm, scyc, idle_seen, exp_err ? TO : t_lat[e.i][e.k], e.first);
        end
        idle_seen = 1'b0;
        k[e.i]++;
        if (k[e.i] >= cnt[e.i]) begin
          req[e.i] = 1'b0;
          lock[e.i] = 1'b0;
        end else load(e.i, k[e.i]);
      end
      prev = strobe;
    end
    checks++;
    if (ord.size() != 0) begin
      errors++;
      $display("FAIL %s_budget: got %0d accesses still outstanding, want 0", nm, ord.size());
    end
    req = '0;
    lock = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (ack !== '0) begin
        errors++;
        $display("FAIL %s_quiet: got ack=%b want 0", nm, ack);
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    req = '0;
    lock = '0;
    we = '0;
    addr = '0;
    wdata = '0;
    width = '0;
    repeat (3) tick();
    checks++;
    if (ack !== '0 || err !== 1'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_resp: got ack=%b err=%b rdata=%h want 0 0 0", ack, err, rdata);
    end
    checks++;
    if (gnt !== '0 || m_read !== 1'b0 || m_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got gnt=%b rd=%b wr=%b want 0 0 0", gnt, m_read, m_write);
    end
    checks++;
    if (m_addr !== 32'h0 || m_wdata !== 32'h0 || m_width !== W_WORD) begin
      errors++;
      $display("FAIL reset_bus: got a=%h d=%h w=%0d want 0 0 2", m_addr, m_wdata, m_width);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    int rc = 0, first = -1, last = -1, ackc = -1, nack = 0;
    logic [N-1:0] a = '0;
    logic [31:0] rd = '0, ma = '0;
    logic e = 1'b0;
    mem_q.delete();
    mem_q.push_back('{3, 32'hE3A00001});
    addr[32*REQ_CPU +: 32] = 32'h0800_0000;
    we[REQ_CPU] = 1'b0;
    width[2*REQ_CPU +: 2] = W_WORD;
    req[REQ_CPU] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (m_read) begin
        rc++;
        if (first < 0) begin
          first = c;
          ma = m_addr;
        end
        last = c;
      end
      if (ack != '0) begin
        nack++;
        if (ackc < 0) begin
          ackc = c;
          a = ack;
          rd = rdata;
          e = err;
        end
        req[REQ_CPU] = 1'b0;
      end
    end
    checks++;
    if (first !== 1 || ma !== 32'h0800_0000) begin
      errors++;
      $display("FAIL read_issue: got first_cycle=%0d addr=%h want 1 08000000", first, ma);
    end
    checks++;
    if (rc !== 3 || ackc !== last + 1) begin
      errors++;
      $display("FAIL read_timing: got read_cycles=%0d ack_cycle=%0d want 3 %0d", rc, ackc, last + 1);
    end
    checks++;
    if (a !== 5'b10000 || rd !== 32'hE3A00001 || e !== 1'b0 || nack !== 1) begin
      errors++;
      $display("FAIL read_ack: got ack=%b rdata=%h err=%b n=%0d want 10000 e3a00001 0 1", a, rd, e, nack);
    end
  endtask

  task automatic test_simultaneous();
    clear_cfg();
    fill(2, 2, 0);
    cnt[REQ_CPU] = 1;
    cnt[REQ_DMA1] = 1;
    run_scenario("simul");
  endtask

  task automatic test_burst();
    clear_cfg();
    fill(1, 3, 0);
    cnt[REQ_DMA0] = 20;
    lockm[REQ_DMA0] = 1'b1;
    cnt[REQ_CPU] = 1;
    for (int k = 0; k < MAXT; k++) t_we[REQ_DMA0][k] = 1'b1;
    run_scenario("burst");
  endtask

  task automatic test_burst_handover();
    clear_cfg();
    fill(1, 2, 0);
    cnt[REQ_DMA0] = 16;
    lockm[REQ_DMA0] = 1'b1;
    cnt[REQ_CPU] = 2;
    for (int k = 0; k < MAXT; k++) t_we[REQ_DMA0][k] = 1'b1;
    run_scenario("handover");
  endtask

  task automatic test_timeout();
    clear_cfg();
    fill(2, 2, 0);
    cnt[REQ_DMA2] = 2;
    t_lat[REQ_DMA2][0] = 0;
    run_scenario("timeout");
  endtask

  task automatic test_reset_mid();
    bit got = 1'b0;
    mem_q.delete();
    mem_q.push_back('{0, 32'h0});
    addr[32*REQ_CPU +: 32] = 32'h0000_0100;
    we[REQ_CPU] = 1'b0;
    req[REQ_CPU] = 1'b1;
    tick();
    checks++;
    if (m_read !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_start: got m_read=%b want 1", m_read);
    end
    tick();
    tick();
    rstn = 1'b0;
    tick();
    checks++;
    if (m_read !== 1'b0 || gnt !== '0 || ack !== '0) begin
      errors++;
      $display("FAIL rstmid_abort: got rd=%b gnt=%b ack=%b want 0 0 0", m_read, gnt, ack);
    end
    tick();
    checks++;
    if (ack !== '0) begin
      errors++;
      $display("FAIL rstmid_noack: got ack=%b want 0", ack);
    end
    mem_q.push_back('{2, 32'h1234_5678});
    rstn = 1'b1;
    tick();
    checks++;
    if (m_read !== 1'b1 || gnt !== 5'b10000) begin
      errors++;
      $display("FAIL rstmid_restart: got rd=%b gnt=%b want 1 10000", m_read, gnt);
    end
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      if (ack != '0) begin
        got = 1'b1;
        checks++;
        if (ack !== 5'b10000 || rdata !== 32'h1234_5678 || err !== 1'b0) begin
          errors++;
          $display("FAIL rstmid_ack: got ack=%b rdata=%h err=%b want 10000 12345678 0", ack, rdata, err);
        end
        req[REQ_CPU] = 1'b0;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL rstmid_wait: got no ack within 20 cycles, want ack");
    end
    req = '0;
    repeat (3) tick();
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      clear_cfg();
      fill(1, 6, 15);
      for (int i = 0; i < N; i++) begin
        cnt[i] = $urandom_range(0, 5);
        lockm[i] = 1'($urandom_range(0, 1));
      end
      glitch = 1'b1;
      run_scenario("random");
      glitch = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_burst();
    test_burst_handover();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
